e3_prod_split: RTL and testbench



---
 rtl/e3_prod_split.sv | 90 +++++++++
 tb/tb_e3_prod_split.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/e3_prod_split.sv
// Splits an excess-3 multiplier result (binary product + 3) into tens/units excess-3 digits
// by repeated subtract-10, one step per clock. Optional range check: define E3_RANGE_CHECK_EN.
module e3_prod_split #(
  parameter int MAX_PROD = 81
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_digits,
  output logic       out_err
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t     state;
  logic [7:0] rem;
  logic [3:0] tens;
  logic [7:0] digits_q;

`ifdef E3_RANGE_CHECK_EN
  localparam logic [7:0] MAX_P = 8'(MAX_PROD);

  logic err_q;
  logic range_bad;

  // Inputs below the excess-3 bias or above the largest legal product skip conversion.
  assign range_bad = (in_data < 8'd3) || ((in_data - 8'd3) > MAX_P);
  assign out_err   = err_q;
`else
  assign out_err   = 1'b0;
`endif

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_digits = digits_q;

  // Tens counts modulo 10, so unchecked inputs come out as (value mod 100).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem      <= 8'd0;
      tens     <= 4'd0;
      digits_q <= 8'b0011_0011;
`ifdef E3_RANGE_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rem  <= in_data - 8'd3;
            tens <= 4'd0;
`ifdef E3_RANGE_CHECK_EN
            if (range_bad) begin
              digits_q <= 8'b0011_0011;
              err_q    <= 1'b1;
              state    <= DONE;
            end else begin
              state <= CONV;
            end
`else
            state <= CONV;
`endif
          end
        end
        CONV: begin
          if (rem >= 8'd10) begin
            rem  <= rem - 8'd10;
            tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
          end else begin
            digits_q <= {tens + 4'd3, rem[3:0] + 4'd3};
`ifdef E3_RANGE_CHECK_EN
            err_q    <= 1'b0;
`endif
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e3_prod_split.sv
// Randomized self-checking bench for e3_prod_split against a decimal-arithmetic reference model.
module tb_e3_prod_split;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_digits;
  logic       out_err;

  int n_compared;
  int n_mismatched;

  e3_prod_split #(.MAX_PROD(81)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digits (out_digits),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: decode the biased product, then split it into decimal digits.
  task automatic model(input logic [7:0] d, output logic [7:0] digits, output logic err, output int lat);
    int v;
    v = (int'(d) - 3 + 256) % 256;
`ifdef E3_RANGE_CHECK_EN
    if (d < 3 || v > 81) begin
      digits = 8'h33;
      err    = 1'b1;
      lat    = 1;
      return;
    end
`endif
    digits = {4'((v / 10) % 10 + 3), 4'(v % 10 + 3)};
    err    = 1'b0;
    lat    = v / 10 + 1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input int hold);
    logic [7:0] exp_digits;
    logic       exp_err;
    int         exp_lat;
    int         n;
    logic       busy_ok;
    logic       stable_ok;
    logic [7:0] held;

    model(d, exp_digits, exp_err, exp_lat);
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);

    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'($urandom);
    busy_ok = 1'b1;
    n = 0;
    while (!out_valid && n < 200) begin
      if (in_ready) busy_ok = 1'b0;
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    checkOutput($sformatf("latency_%02h", d), 32'(n), 32'(exp_lat));
    checkOutput($sformatf("busy_in_ready_%02h", d), 32'(busy_ok), 32'd1);
    checkOutput($sformatf("digits_%02h", d), 32'(out_digits), 32'(exp_digits));
    checkOutput($sformatf("err_%02h", d), 32'(out_err), 32'(exp_err));

    held      = out_digits;
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || in_ready || out_digits !== held) stable_ok = 1'b0;
    end
    checkOutput($sformatf("hold_stable_%02h", d), 32'(stable_ok), 32'd1);

    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("ready_after_pop", 32'(in_ready), 32'd1);
    checkOutput("valid_after_pop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_digits", 32'(out_digits), 32'h33);
    checkOutput("rst_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(8'h54, 0);
    applyStimulus(8'h03, 0);
    applyStimulus(8'h0F, 1);
    applyStimulus(8'h1B, 5);
    applyStimulus(8'h60, 2);
    applyStimulus(8'h02, 0);
    applyStimulus(8'hFF, 1);
    applyStimulus(8'h00, 0);

    // Asynchronous reset mid-conversion, checked between clock edges.
    in_valid = 1'b1;
    in_data  = 8'h54;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_digits", 32'(out_digits), 32'h33);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h2A, 0);

    for (int k = 0; k < 40; k++) begin
      applyStimulus(8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
